// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-input round-robin arbiter slice.
package mux_arb_pkg;

  localparam int DATA_W_DEF = 8;

  // The output slot is either free or holds one beat.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Requester identity, also used as the priority pointer value.
  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  // A lone requester always wins; on contention the priority pointer decides.
  function automatic src_e rr_grant(logic a_v, logic b_v, src_e prio);
    if (a_v && b_v) return prio;
    else if (b_v)   return SRC_B;
    else            return SRC_A;
  endfunction

  // The loser of this grant becomes the favoured requester next time.
  function automatic src_e other_src(src_e s);
    return (s == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle for the arbiter: two requester ports and one output port.
interface mux2_rr_arbiter_if #(
  parameter int DATA_W = mux_arb_pkg::DATA_W_DEF
);

  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  logic              y_valid;
  logic [DATA_W-1:0] y_data;
  logic              y_src;
  logic              y_ready;

  // Environment side: drives requests and downstream ready.
  modport master (
    output a_valid, a_data, b_valid, b_data, y_ready,
    input  a_ready, b_ready, y_valid, y_data, y_src
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_data, b_valid, b_data, y_ready,
    output a_ready, b_ready, y_valid, y_data, y_src
  );

endinterface

// File: rtl/mux2_data.sv
// DATA_W-wide 2:1 payload select steered by the current grant.
module mux2_data
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a_data_i,
  input  logic [DATA_W-1:0] b_data_i,
  input  src_e              sel_i,
  output logic [DATA_W-1:0] y_data_o
);

  assign y_data_o = (sel_i == SRC_B) ? b_data_i : a_data_i;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a single registered output slot.
// The slot refills in the same cycle it drains, so full throughput is kept
// while downstream is ready.
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  mux2_rr_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  src_e              prio_q,  prio_d;
  src_e              y_src_q, y_src_d;
  logic [DATA_W-1:0] y_data_q, y_data_d;

  logic              slot_free;
  logic              accept;
  src_e              grant;
  logic [DATA_W-1:0] sel_data;

  // Grant and handshake: the slot is free when empty or when draining now.
  // Reset masks the readies so nothing is accepted during a reset cycle.
  always_comb begin
    slot_free = (state_q == EMPTY) || bus.y_ready;
    grant     = rr_grant(bus.a_valid, bus.b_valid, prio_q);
    accept    = !rst && slot_free && (bus.a_valid || bus.b_valid);
  end

  assign bus.a_ready = accept && (grant == SRC_A);
  assign bus.b_ready = accept && (grant == SRC_B);

  mux2_data #(.DATA_W(DATA_W)) u_data (
    .a_data_i (bus.a_data),
    .b_data_i (bus.b_data),
    .sel_i    (grant),
    .y_data_o (sel_data)
  );

  // Next state: slot occupancy, held payload and priority pointer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    prio_d   = prio_q;
    y_src_d  = y_src_q;
    y_data_d = y_data_q;

    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)           state_d = FULL;
        else if (bus.y_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    if (accept) begin
      y_data_d = sel_data;
      y_src_d  = grant;
      prio_d   = other_src(grant);
    end
  end

  // State and output registers; reset drops any held beat and favours A.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q  <= EMPTY;
      prio_q   <= SRC_A;
      y_src_q  <= SRC_A;
      y_data_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      y_src_q  <= y_src_d;
      y_data_q <= y_data_d;
    end
  end

  assign bus.y_valid = (state_q == FULL);
  assign bus.y_data  = y_data_q;
  assign bus.y_src   = y_src_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter with a reference handshake model and a
// scoreboard queue of accepted beats awaiting delivery.
module tb_mux2_rr_arbiter;

  typedef struct packed {
    logic       src;
    logic [7:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  mux2_rr_arbiter_if #(.DATA_W(8)) bus ();

  mux2_rr_arbiter #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t sb_q[$];
  logic  m_full = 1'b0;
  logic  m_prio = 1'b0;
  logic  m_acc_a, m_acc_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: at the falling edge compare against the model, then advance
  // the model to what the coming rising edge will do.
  task automatic cycle();
    logic  free, acc, g;
    beat_t b;
    @(negedge clk);
    free = !m_full || bus.y_ready;
    g    = (bus.a_valid && bus.b_valid) ? m_prio : bus.b_valid;
    acc  = !rst && free && (bus.a_valid || bus.b_valid);
    check("a_ready", {31'd0, bus.a_ready}, {31'd0, acc && !g});
    check("b_ready", {31'd0, bus.b_ready}, {31'd0, acc && g});
    check("y_valid", {31'd0, bus.y_valid}, {31'd0, m_full});
    if (m_full && sb_q.size() > 0) begin
      check("y_data", {24'd0, bus.y_data}, {24'd0, sb_q[0].data});
      check("y_src",  {31'd0, bus.y_src},  {31'd0, sb_q[0].src});
    end
    m_acc_a = 1'b0;
    m_acc_b = 1'b0;
    if (rst) begin
      m_full = 1'b0;
      m_prio = 1'b0;
      sb_q.delete();
    end else begin
      if (m_full && bus.y_ready && sb_q.size() > 0) void'(sb_q.pop_front());
      if (acc) begin
        b.src  = g;
        b.data = g ? bus.b_data : bus.a_data;
        sb_q.push_back(b);
        m_full = 1'b1;
        m_prio = !g;
        m_acc_a = !g;
        m_acc_b = g;
      end else if (bus.y_ready) begin
        m_full = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Both requesters busy for n cycles; each payload advances once taken.
  task automatic contend(input int n, input logic first_src);
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.a_data  = 8'hA0;
    bus.b_data  = 8'hB0;
    bus.y_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (i == 0) check("first_grant_src", {31'd0, bus.y_src}, {31'd0, first_src});
      if (m_acc_a) bus.a_data = bus.a_data + 8'd1;
      if (m_acc_b) bus.b_data = bus.b_data + 8'd1;
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    cycle();
    cycle();
    check("drained", sb_q.size(), 0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.a_data  = 8'h5A;
    bus.b_data  = 8'hA5;
    bus.y_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles with both requesters active.
    cycle();
    cycle();
    rst         = 1'b0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    check("rst_y_valid", {31'd0, bus.y_valid}, 32'd0);
    check("rst_y_data",  {24'd0, bus.y_data},  32'd0);
    check("rst_y_src",   {31'd0, bus.y_src},   32'd0);
    cycle();

    // Single requester A, one-cycle latency.
    bus.a_valid = 1'b1;
    bus.a_data  = 8'h11;
    cycle();
    bus.a_valid = 1'b0;
    check("single_y_valid", {31'd0, bus.y_valid}, 32'd1);
    check("single_y_data",  {24'd0, bus.y_data},  32'h11);
    check("single_y_src",   {31'd0, bus.y_src},   32'd0);
    cycle();

    // Two idle cycles; priority remembers that A went last, so B wins first.
    cycle();
    cycle();
    contend(6, 1'b1);

    // Backpressure: slot held by A while B waits.
    bus.a_valid = 1'b1;
    bus.a_data  = 8'h33;
    bus.y_ready = 1'b0;
    cycle();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b1;
    bus.b_data  = 8'h44;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_b_ready", {31'd0, bus.b_ready}, 32'd0);
      cycle();
      check("bp_y_data", {24'd0, bus.y_data}, 32'h33);
    end
    bus.y_ready = 1'b1;
    #1;
    check("bp_release_b_ready", {31'd0, bus.b_ready}, 32'd1);
    cycle();
    bus.b_valid = 1'b0;
    check("bp_y_src",  {31'd0, bus.y_src},  32'd1);
    check("bp_y_data2", {24'd0, bus.y_data}, 32'h44);
    cycle();
    cycle();

    // Mid-operation reset while FULL: beat discarded, priority back to A.
    bus.a_valid = 1'b1;
    bus.a_data  = 8'h55;
    bus.y_ready = 1'b0;
    cycle();
    check("pre_rst_full", {31'd0, bus.y_valid}, 32'd1);
    rst         = 1'b1;
    bus.b_valid = 1'b1;
    cycle();
    rst         = 1'b0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    check("mid_rst_y_valid", {31'd0, bus.y_valid}, 32'd0);
    bus.y_ready = 1'b1;
    cycle();
    contend(6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
